// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a small write FIFO
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STP_LAST = 1'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t                state, state_d;
  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  wr, pop;
  logic [CW-1:0]         clk_cnt, clk_d;
  logic [IW-1:0]         idx, idx_d;
  logic                  stp, stp_d;
  logic [DATA_BITS-1:0]  data, data_d;
  logic                  serial, serial_d, done, done_d, bit_end, par_bit;

  assign o_Tx_Ready   = count != FULL;
  assign wr           = i_Tx_DV & o_Tx_Ready;
  assign o_Fifo_Count = count;
  assign o_Tx_Active  = state != S_IDLE;
  assign o_Tx_Serial  = serial;
  assign o_Tx_Done    = done;
  assign bit_end      = clk_cnt == CLK_LAST;
  assign par_bit      = ^data ^ (PARITY == 2);

  always_ff @(posedge i_Clock)
    if (wr) mem[wr_ptr] <= i_Tx_Byte;

  // Ready is decoded from count alone, so a full FIFO rejects a write even on a pop edge
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end

  always_comb begin
    state_d = state;
    clk_d   = (state == S_IDLE || bit_end) ? '0 : clk_cnt + 1'b1;
    idx_d   = idx;
    stp_d   = stp;
    data_d  = data;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state)
      S_IDLE: if (count != '0) begin
        pop     = 1'b1;
        data_d  = mem[rd_ptr];
        idx_d   = '0;
        stp_d   = 1'b0;
        state_d = S_START;
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: if (bit_end) begin
        idx_d = idx + 1'b1;
        if (idx == IDX_LAST) begin
          idx_d   = '0;
          state_d = PARITY != 0 ? S_PAR : S_STOP;
        end
      end
      S_PAR: if (bit_end) state_d = S_STOP;
      S_STOP: if (bit_end) begin
        stp_d = stp + 1'b1;
        if (stp == STP_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Line level follows the state being entered so the serial output stays registered
    serial_d = state_d == S_START ? 1'b0 :
               state_d == S_DATA  ? data_d[idx_d] :
               state_d == S_PAR   ? par_bit : 1'b1;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      idx     <= '0;
      stp     <= 1'b0;
      data    <= '0;
      serial  <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      clk_cnt <= clk_d;
      idx     <= idx_d;
      stp     <= stp_d;
      data    <= data_d;
      serial  <= serial_d;
      done    <= done_d;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three differently configured transmitters checked every clock
// against a frame-level model (queue of characters plus a position within the frame)
module tb_uart_tx_fifo;
  logic i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  localparam int CPB   [3] = '{4, 3, 2};
  localparam int DB    [3] = '{8, 7, 9};
  localparam int PAR   [3] = '{0, 1, 2};
  localparam int SB    [3] = '{1, 2, 1};
  localparam int DEPTH [3] = '{4, 4, 2};

  logic       i_Rst_n;
  logic       dv  [3];
  logic [8:0] byt [3];
  logic       ser [3];
  logic       act [3];
  logic       dn  [3];
  logic       rdy [3];
  logic [2:0] cnt0, cnt1;
  logic [1:0] cnt2;

  uart_tx_fifo #(.CLKS_PER_BIT(4)) u0 (
    .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .i_Tx_DV(dv[0]), .i_Tx_Byte(byt[0][7:0]),
    .o_Tx_Ready(rdy[0]), .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]), .o_Tx_Done(dn[0]),
    .o_Fifo_Count(cnt0));

  uart_tx_fifo #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .i_Tx_DV(dv[1]), .i_Tx_Byte(byt[1][6:0]),
    .o_Tx_Ready(rdy[1]), .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]), .o_Tx_Done(dn[1]),
    .o_Fifo_Count(cnt1));

  uart_tx_fifo #(.CLKS_PER_BIT(2), .DATA_BITS(9), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(2)) u2 (
    .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .i_Tx_DV(dv[2]), .i_Tx_Byte(byt[2]),
    .o_Tx_Ready(rdy[2]), .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]), .o_Tx_Done(dn[2]),
    .o_Fifo_Count(cnt2));

  int mq [3][$];
  bit busy [3];
  int t [3];
  int cur [3];
  bit mdone [3];
  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      if (nerr <= 20) $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int flen(input int i);
    return (1 + DB[i] + (PAR[i] != 0 ? 1 : 0) + SB[i]) * CPB[i];
  endfunction

  // Level of serial bit k of a frame: start, data LSB first, optional parity, stop(s)
  function automatic int line_bit(input int i, input int c, input int k);
    if (k == 0) return 0;
    if (k <= DB[i]) return (c >> (k - 1)) & 1;
    if (k == DB[i] + 1 && PAR[i] != 0) return ($countones(c) + (PAR[i] == 2 ? 1 : 0)) % 2;
    return 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      busy[i] = 0;
      t[i] = 0;
      mdone[i] = 0;
    end
  endtask

  task automatic model_step();
    bit w;
    if (!i_Rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      w = dv[i] && mq[i].size() < DEPTH[i];
      mdone[i] = busy[i] && t[i] == flen(i) - 1;
      if (busy[i]) begin
        if (mdone[i]) busy[i] = 0;
        else t[i]++;
      end else if (mq[i].size() > 0) begin
        cur[i] = mq[i].pop_front();
        busy[i] = 1;
        t[i] = 0;
      end
      if (w) mq[i].push_back(int'(byt[i]) & ((1 << DB[i]) - 1));
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("serial[%0d]", i), int'(ser[i]), busy[i] ? line_bit(i, cur[i], t[i] / CPB[i]) : 1);
      check($sformatf("active[%0d]", i), int'(act[i]), int'(busy[i]));
      check($sformatf("done[%0d]", i), int'(dn[i]), int'(mdone[i]));
      check($sformatf("count[%0d]", i), int'(i == 0 ? cnt0 : i == 1 ? cnt1 : {1'b0, cnt2}), mq[i].size());
      check($sformatf("ready[%0d]", i), int'(rdy[i]), mq[i].size() < DEPTH[i] ? 1 : 0);
    end
  endtask

  task automatic tick();
    @(posedge i_Clock);
    model_step();
    #1;
    compare();
    @(negedge i_Clock);
  endtask

  task automatic drive_all(input bit v, input int b);
    for (int i = 0; i < 3; i++) begin
      dv[i] = v;
      byt[i] = b[8:0];
    end
  endtask

  task automatic idle_n(input int n);
    drive_all(0, 0);
    repeat (n) tick();
  endtask

  initial begin
    bit heavy;
    i_Rst_n = 1'b0;
    drive_all(1, 'h1FF);
    model_reset();
    @(negedge i_Clock);
    repeat (3) tick();
    i_Rst_n = 1'b1;
    idle_n(2);
    drive_all(1, 'hA5);
    tick();
    idle_n(60);
    for (int b = 1; b <= 6; b++) begin
      drive_all(1, b);
      tick();
    end
    idle_n(230);
    // Three writes, then reset lands in data bit 3 of the first frame on u0
    drive_all(1, 'h3C); tick();
    drive_all(1, 'h5A); tick();
    drive_all(1, 'h66); tick();
    idle_n(15);
    i_Rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_serial[%0d]", i), int'(ser[i]), 1);
      check($sformatf("rst_active[%0d]", i), int'(act[i]), 0);
      check($sformatf("rst_count[%0d]", i), int'(i == 0 ? cnt0 : i == 1 ? cnt1 : {1'b0, cnt2}), 0);
    end
    model_reset();
    repeat (2) tick();
    i_Rst_n = 1'b1;
    idle_n(80);
    heavy = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) heavy = !heavy;
      for (int i = 0; i < 3; i++) begin
        dv[i] = heavy ? $urandom_range(0, 1) == 0 : $urandom_range(0, 39) == 0;
        byt[i] = 9'($urandom);
      end
      if ($urandom_range(0, 999) == 0) begin
        i_Rst_n = 1'b0;
        tick();
        i_Rst_n = 1'b1;
      end else tick();
    end
    idle_n(120);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
